// File: rtl/x_usr_access_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// x_usr_access_seq : table of user words presented one at a time, plus CFGCLK
// Rev 1.0
// ---------------------------------------------------------------------------
module x_usr_access_seq #(
  parameter int                          DATA_WIDTH     = 32,
  parameter int                          DEPTH          = 4,
  parameter int                          CLK_DIV        = 4,
  parameter int                          STARTUP_CYCLES = 16,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_DATA      = '0,
  parameter bit                          AUTO_ADVANCE   = 1'b0,
  localparam int                         c_aw           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [c_aw-1:0]       load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  adv,
  output logic                  cfgclk,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  datavalid,
  output logic [c_aw-1:0]       dataidx
);

  localparam int              c_dw       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              c_sw       = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
  localparam logic [c_sw-1:0] c_su_last  = c_sw'(STARTUP_CYCLES - 1);
  localparam logic [c_aw-1:0] c_idx_last = c_aw'(DEPTH - 1);
  localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_VALID   = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_table [DEPTH];
  logic [c_dw-1:0]       r_div_cnt;
  logic [c_sw-1:0]       r_su_cnt;

  logic                  w_addr_ok;
  logic                  w_cfg_rise;
  logic                  w_adv_evt;
  logic [c_aw-1:0]       w_rd_idx;
  logic [c_aw-1:0]       w_idx_next;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_addr_ok  = ({1'b0, load_addr} < c_depth);
  // Asserted on the edge at which cfgclk goes from 0 to 1.
  assign w_cfg_rise = (r_div_cnt == c_div_last) && !cfgclk;
  assign w_adv_evt  = AUTO_ADVANCE ? w_cfg_rise : adv;
  assign w_rd_idx   = (r_state == ST_STARTUP) ? '0 : dataidx;
  assign w_idx_next = (dataidx == c_idx_last) ? '0 : dataidx + 1'b1;
  // Write-first: a same-edge write to the word being read is forwarded.
  assign w_rd_word  = (load_en && w_addr_ok && (load_addr == w_rd_idx)) ? load_data
                                                                       : r_table[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= INIT_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (load_en && w_addr_ok) begin
      r_table[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      cfgclk    <= 1'b0;
    end else if (r_div_cnt == c_div_last) begin
      r_div_cnt <= '0;
      cfgclk    <= ~cfgclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STARTUP;
      r_su_cnt  <= '0;
      data      <= '0;
      datavalid <= 1'b0;
      dataidx   <= '0;
    end else begin
      case (r_state)
        ST_STARTUP: begin
          if (r_su_cnt == c_su_last) begin
            data      <= w_rd_word;
            dataidx   <= '0;
            datavalid <= 1'b1;
            r_state   <= ST_VALID;
          end else begin
            r_su_cnt <= r_su_cnt + 1'b1;
          end
        end
        ST_VALID: begin
          if (w_adv_evt) begin
            datavalid <= 1'b0;
            dataidx   <= w_idx_next;
            r_state   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          data      <= w_rd_word;
          datavalid <= 1'b1;
          r_state   <= ST_VALID;
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_usr_access_seq.sv
`default_nettype none
// Bench for x_usr_access_seq: ADV-driven instance and AUTO_ADVANCE instance,
// scoreboarded against a cycle-count reference model of the sequencing rules.
module tb_x_usr_access_seq;

  localparam int DEPTH = 4;
  localparam int CD_A  = 4;
  localparam int SU_A  = 16;
  localparam int CD_B  = 2;
  localparam int SU_B  = 3;
  localparam logic [127:0] INIT_A = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] INIT_B = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic        load_en, adv;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        a_cfg, a_dv, b_cfg, b_dv;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_idx, b_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, one slot per instance
  logic [31:0] m_tab [2][DEPTH];
  int          m_idx [2];
  int          m_cyc [2];
  bit          m_valid [2];
  bit          m_pend [2];
  bit          m_started [2];
  exp_t        qa[$];
  exp_t        qb[$];
  bit          p_dv [2];
  logic [31:0] p_data [2];

  x_usr_access_seq #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .CLK_DIV(CD_A), .STARTUP_CYCLES(SU_A),
    .INIT_DATA(INIT_A), .AUTO_ADVANCE(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .adv(adv), .cfgclk(a_cfg), .data(a_data),
    .datavalid(a_dv), .dataidx(a_idx)
  );

  x_usr_access_seq #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .CLK_DIV(CD_B), .STARTUP_CYCLES(SU_B),
    .INIT_DATA(INIT_B), .AUTO_ADVANCE(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .adv(adv), .cfgclk(b_cfg), .data(b_data),
    .datavalid(b_dv), .dataidx(b_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    logic [127:0] iv;
    iv = (d == 0) ? INIT_A : INIT_B;
    for (int i = 0; i < DEPTH; i++) m_tab[d][i] = iv[i*32 +: 32];
    m_idx[d] = 0; m_cyc[d] = 0;
    m_valid[d] = 0; m_pend[d] = 0; m_started[d] = 0;
    if (d == 0) qa.delete(); else qb.delete();
  endtask

  task automatic push(input int d, input int idx, input logic [31:0] dat);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = dat;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // One rising edge of instance d, applied with the inputs currently driven.
  task automatic step(input int d);
    bit evt;
    m_cyc[d]++;
    if (load_en) m_tab[d][load_addr] = load_data;
    evt = (d == 0) ? adv : ((m_cyc[d] % (2 * CD_B)) == CD_B);
    if (!m_started[d]) begin
      if (m_cyc[d] == ((d == 0) ? SU_A : SU_B)) begin
        m_started[d] = 1; m_valid[d] = 1; m_idx[d] = 0;
        push(d, 0, m_tab[d][0]);
      end
    end else if (m_pend[d]) begin
      m_pend[d] = 0; m_valid[d] = 1;
      push(d, m_idx[d], m_tab[d][m_idx[d]]);
    end else if (evt) begin
      m_idx[d] = (m_idx[d] + 1) % DEPTH;
      m_pend[d] = 1; m_valid[d] = 0;
    end
  endtask

  task automatic cycle(input bit a, input bit le, input logic [1:0] la, input logic [31:0] ld);
    adv = a; load_en = le; load_addr = la; load_data = ld;
    @(posedge clk);
    if (rst_a_n) step(0);
    if (rst_b_n) step(1);
    @(negedge clk);
  endtask

  task automatic mon(input int d, input logic rn, input logic dv, input logic [31:0] dat,
                     input logic [1:0] idx, input logic cfg);
    exp_t e;
    int   cd;
    if (!rn) begin
      p_dv[d] = 0;
    end else begin
      cd = (d == 0) ? CD_A : CD_B;
      chk($sformatf("%0d.datavalid@%0d", d, m_cyc[d]), 32'(dv), 32'(m_valid[d]));
      chk($sformatf("%0d.cfgclk@%0d", d, m_cyc[d]), 32'(cfg), 32'((m_cyc[d] / cd) % 2));
      if (dv && !p_dv[d]) begin
        if ((d == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
          n_checks++; n_fail++;
          $display("FAIL %0d.unexpected_valid: got datavalid rise with data %h, expected none", d, dat);
        end else begin
          if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
          chk($sformatf("%0d.data", d), dat, e.data);
          chk($sformatf("%0d.dataidx", d), 32'(idx), 32'(e.idx));
        end
      end else if (dv && p_dv[d]) begin
        chk($sformatf("%0d.data_stable", d), dat, p_data[d]);
      end
      p_dv[d] = dv;
      p_data[d] = dat;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_a_n, a_dv, a_data, a_idx, a_cfg);
    mon(1, rst_b_n, b_dv, b_data, b_idx, b_cfg);
  end

  initial begin
    int  idx0;
    bit  found;
    rst_a_n = 0; rst_b_n = 0;
    adv = 0; load_en = 0; load_addr = '0; load_data = '0;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    chk("reset.a_dv", 32'(a_dv), 0);
    chk("reset.a_data", a_data, 0);
    chk("reset.a_idx", 32'(a_idx), 0);
    chk("reset.a_cfg", 32'(a_cfg), 0);
    chk("reset.b_data", b_data, 0);
    rst_a_n = 1; rst_b_n = 1;

    // ADV during startup is ignored; write entry 1 during startup
    for (int i = 0; i < 20; i++) cycle(i == 5 || i == 9, i == 7, 2'd1, 32'h12345678);
    chk("startup.a_data", a_data, 32'hAAAA0000);

    for (int p = 0; p < 5; p++) begin
      cycle(1, 0, 2'd0, 32'h0);
      repeat (3) cycle(0, 0, 2'd0, 32'h0);
    end

    idx0 = m_idx[0];
    repeat (6) cycle(1, 0, 2'd0, 32'h0);
    cycle(0, 0, 2'd0, 32'h0);
    chk("held_adv.idx", 32'(a_idx), 32'((idx0 + 3) % DEPTH));

    // bring index to 1, then write entry 2 on the edge that reads it
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (m_valid[0] && m_idx[0] == 1) found = 1;
      else begin
        cycle(1, 0, 2'd0, 32'h0);
        cycle(0, 0, 2'd0, 32'h0);
      end
    end
    chk("wf.found", 32'(found), 1);
    cycle(1, 0, 2'd0, 32'h0);
    cycle(0, 1, 2'd2, 32'hCAFEF00D);
    cycle(0, 0, 2'd0, 32'h0);
    chk("wf.data", a_data, 32'hCAFEF00D);
    chk("wf.idx", 32'(a_idx), 2);

    repeat (300) cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                       2'($urandom_range(0, 3)), $urandom);

    // reset the auto-advance instance while it is in its update cycle
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_pend[1]) found = 1;
      else cycle(0, 0, 2'd0, 32'h0);
    end
    chk("midreset.found", 32'(found), 1);
    rst_b_n = 0;
    #1;
    chk("midreset.b_dv", 32'(b_dv), 0);
    chk("midreset.b_data", b_data, 0);
    chk("midreset.b_idx", 32'(b_idx), 0);
    chk("midreset.b_cfg", 32'(b_cfg), 0);
    model_reset(1);
    repeat (2) cycle(0, 0, 2'd0, 32'h0);
    rst_b_n = 1;
    repeat (4) cycle(0, 0, 2'd0, 32'h0);
    chk("reload.b_data", b_data, 32'h11110001);
    repeat (36) cycle(0, 0, 2'd0, 32'h0);

    chk("qa.empty", 32'(qa.size()), 0);
    chk("qb.empty", 32'(qb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_usr_access_seq.md
Name: x_usr_access_seq

Overview:
- Parametrised behavioural successor to the single-word user-access primitive.
- Holds a table of DEPTH user words, each DATA_WIDTH bits, preloaded from INIT_DATA and rewritable at run time.
- After a programmable startup delay, presents one word at a time on DATA, qualified by DATAVALID, and steps through the table on request.
- Generates a free-running divided configuration clock CFGCLK. Used in simulation and bring-up benches in place of the fixed 32-bit primitive.

Parameters:
DATA_WIDTH, 32, width of each user word and of DATA.
DEPTH, 4, number of table entries; must be >= 1.
CLK_DIV, 4, CFGCLK half-period in CLK cycles; must be >= 1.
STARTUP_CYCLES, 16, CLK cycles from reset release until DATAVALID first asserts; must be >= 1.
INIT_DATA, all zeros, DEPTH*DATA_WIDTH bits; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
AUTO_ADVANCE, 0, 1 = step to the next entry on every CFGCLK rising edge instead of on ADV.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST_N  input  1  asynchronous active-low reset.
LOAD_EN  input  1  write strobe for the table.
LOAD_ADDR  input  clog2(DEPTH), minimum 1  table index to write.
LOAD_DATA  input  DATA_WIDTH  word to write.
ADV  input  1  single-cycle request to present the next entry; ignored when AUTO_ADVANCE=1.
CFGCLK  output  1  divided clock.
DATA  output  DATA_WIDTH  currently presented word.
DATAVALID  output  1  DATA is stable and valid.
DATAIDX  output  clog2(DEPTH), minimum 1  index of the presented word.

Behaviour:
- Reset, asynchronous on RST_N low:
  - Table reloads from INIT_DATA.
  - CFGCLK=0, DATA=0, DATAVALID=0, DATAIDX=0.
  - Divider counter and startup counter clear; state=STARTUP.
  - Reset asserted mid-operation aborts everything immediately.
- CFGCLK:
  - Toggles every CLK_DIV CLK cycles from the first rising edge after RST_N rises.
  - With CLK_DIV=4, the first high phase starts 4 cycles after release; period is 8 CLK cycles.
  - Runs in all states.
- State machine:
  - STARTUP: counts CLK cycles. When the count reaches STARTUP_CYCLES, next edge loads DATA=table[0], DATAIDX=0, DATAVALID=1, and moves to VALID. Total: DATAVALID rises on the STARTUP_CYCLES-th rising edge after release.
  - VALID: holds DATA, DATAVALID=1. An advance event (ADV=1 when AUTO_ADVANCE=0; CFGCLK rising transition when AUTO_ADVANCE=1) moves to UPDATE, drops DATAVALID to 0, and sets DATAIDX=(DATAIDX+1) mod DEPTH.
  - UPDATE: lasts exactly one cycle. Loads DATA=table[DATAIDX], sets DATAVALID=1, returns to VALID.
  - Net latency ADV to new valid DATA is 2 cycles; DATAVALID is low for exactly 1 cycle.
- Index wrap: DATAIDX wraps from DEPTH-1 to 0. With DEPTH=1, ADV still produces the 1-cycle DATAVALID drop and re-presents entry 0.
- ADV when not accepted:
  - ADV in STARTUP or UPDATE is ignored, not queued.
  - ADV held high for several cycles advances once per VALID visit, i.e. every 2 cycles.
- Table writes:
  - LOAD_EN writes table[LOAD_ADDR]=LOAD_DATA on the rising edge, in any state including STARTUP.
  - LOAD_ADDR >= DEPTH is ignored.
  - Writing the presented index does not change DATA until the next UPDATE. DATA only changes at STARTUP exit or in UPDATE.
  - Write in the same cycle as the UPDATE read of the same index: UPDATE loads the new LOAD_DATA (write-first).
- DATA and DATAIDX are registered outputs. DATA never changes while DATAVALID=1.

Test Plan:
- Reset release with default parameters -> DATAVALID=0 for 15 edges, 1 at edge 16; DATA=0, DATAIDX=0; CFGCLK period 8 CLK.
- INIT_DATA={32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, four ADV pulses after valid -> DATA sequence AAAA0000, BBBB0001, CCCC0002, DDDD0003, AAAA0000; DATAVALID low exactly 1 cycle per step; DATAIDX wraps 3->0.
- LOAD_EN with LOAD_ADDR=1, LOAD_DATA=32'h12345678 during STARTUP, then one ADV -> DATA=12345678, DATAIDX=1.
- ADV held high for 6 cycles in VALID -> exactly 3 advances; ADV during STARTUP produces no change.
- Write table[2]=32'hCAFEF00D in the same cycle UPDATE reads index 2 -> DATA=CAFEF00D (write-first).
- AUTO_ADVANCE=1, CLK_DIV=2 -> DATAIDX increments every 4 CLK cycles; assert RST_N=0 mid-UPDATE -> all outputs 0 immediately; after release, STARTUP repeats and table is back to INIT_DATA.
